// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Purpose:
//   Bridges single-cycle transfer requests from the CPU control unit onto an
//   APB bus. Each request runs one SETUP cycle and one or more ACCESS cycles.
//   Completion is signalled with a one-cycle apb_done pulse. Read data is
//   returned on apb_rdata. Slave errors are collected in a sticky apb_err flag.
//
// Configuration macro:
//   APB_TIMEOUT_EN - when defined, an ACCESS phase that waits TIMEOUT_CYCLES
//                    cycles without pready is aborted. The abort pulses
//                    apb_done, zeroes read data and sets apb_err. When the
//                    macro is undefined, ACCESS waits forever and no counter
//                    is built.
//
// Parameters:
//   APB_ADDR_W     - width of apb_addr / paddr
//   TIMEOUT_CYCLES - ACCESS wait limit (only meaningful with APB_TIMEOUT_EN)
//
// Ports:
//   cpu_clk, cpu_resetn   - clock (rising edge), async active-low reset
//   apb_req, apb_wr,
//   apb_addr              - transfer request, direction and address from CPU
//   apb_err_clr           - clears the sticky error flag
//   pready, pslverr,
//   prdata                - APB slave response
//   psel, penable,
//   pwrite, paddr         - APB master outputs
//   apb_busy              - CPU stall (request pending or transfer in flight)
//   apb_done              - one-cycle completion pulse
//   apb_rdata             - registered read data
//   apb_err               - sticky slave-error / timeout flag
// -----------------------------------------------------------------------------
module apb_master #(
   parameter int APB_ADDR_W     = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_resetn,
   input  logic                  apb_req,
   input  logic                  apb_wr,
   input  logic [APB_ADDR_W-1:0] apb_addr,
   input  logic                  apb_err_clr,
   input  logic                  pready,
   input  logic                  pslverr,
   input  logic [31:0]           prdata,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [APB_ADDR_W-1:0] paddr,
   output logic                  apb_busy,
   output logic                  apb_done,
   output logic [31:0]           apb_rdata,
   output logic                  apb_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic                  apb_done_q, apb_done_d;
   logic [31:0]           apb_rdata_q, apb_rdata_d;
   logic                  apb_err_q, apb_err_d;
   logic                  err_set;

   // A zero limit would abort every transfer before the slave can answer.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef APB_TIMEOUT_EN
   // The counter holds the number of ACCESS cycles already spent waiting.
   // The abort fires in the cycle that would be wait number TIMEOUT_CYCLES.
   localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

   // Next-state and datapath logic.
   // paddr/pwrite load only when a request is accepted in IDLE, so they hold
   // through SETUP and every ACCESS cycle. Requests seen in SETUP or ACCESS
   // fall through the case untouched and are dropped.
   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      apb_done_d  = 1'b0;
      apb_rdata_d = apb_rdata_q;
      err_set     = 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_d   = '0;
`endif

      case (state_q)
         IDLE: begin
            if (apb_req) begin
               paddr_d  = apb_addr;
               pwrite_d = apb_wr;
               state_d  = SETUP;
            end
         end

         SETUP: begin
            state_d = ACCESS;
         end

         ACCESS: begin
            if (pready) begin
               state_d    = IDLE;
               apb_done_d = 1'b1;
               if (!pwrite_q) begin
                  apb_rdata_d = prdata;
               end
               // pslverr is qualified by pready; the transfer still completes.
               if (pslverr) begin
                  err_set = 1'b1;
               end
            end
`ifdef APB_TIMEOUT_EN
            else if (tmo_cnt_q == CNT_LAST) begin
               state_d    = IDLE;
               apb_done_d = 1'b1;
               err_set    = 1'b1;
               if (!pwrite_q) begin
                  apb_rdata_d = '0;
               end
            end
            else begin
               tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
`endif
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Set has priority so an error that lands with a clear is not lost.
      if (err_set) begin
         apb_err_d = 1'b1;
      end
      else if (apb_err_clr) begin
         apb_err_d = 1'b0;
      end
      else begin
         apb_err_d = apb_err_q;
      end
   end

   // State and datapath registers. Reset drops the bus immediately and
   // discards any transfer in flight without a completion pulse.
   always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state_q     <= IDLE;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         apb_done_q  <= 1'b0;
         apb_rdata_q <= '0;
         apb_err_q   <= 1'b0;
      end
      else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         apb_done_q  <= apb_done_d;
         apb_rdata_q <= apb_rdata_d;
         apb_err_q   <= apb_err_d;
      end
   end

`ifdef APB_TIMEOUT_EN
   // Wait counter; cleared whenever the FSM is outside ACCESS.
   always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         tmo_cnt_q <= '0;
      end
      else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`endif

   // psel/penable are decoded straight from the state register. Reset forces
   // them low asynchronously.
   assign psel      = (state_q != IDLE);
   assign penable   = (state_q == ACCESS);
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign apb_done  = apb_done_q;
   assign apb_rdata = apb_rdata_q;
   assign apb_err   = apb_err_q;

   // The CPU must stall in the request cycle itself, before the FSM has moved.
   assign apb_busy  = apb_req | (state_q != IDLE);

endmodule
